// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
//   rx_state_t      : receiver FSM states
//   PAR_MODE_*      : parity sense of the parity bit
//   rx_flags_t      : per-frame error flags stored alongside the payload
//   parity_mismatch : parity check on a pre-reduced data XOR
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    // The payload width is a module parameter, so the full entry struct is
    // declared locally in uart_rx_fifo; only the fixed flag part lives here.
    typedef struct packed {
        logic frame_err;
        logic parity_err;
    } rx_flags_t;

    // data_xor is the XOR of all payload bits. Even parity expects an overall
    // XOR (data plus parity bit) of 0, odd parity expects 1.
    function automatic logic parity_mismatch(input logic data_xor,
                                             input logic par_bit,
                                             input logic odd_mode);
        return (data_xor ^ par_bit) != odd_mode;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count.
//   clk, reset    : clock, asynchronous active-low reset
//   push, push_data : write request and data; ignored when full unless a
//                   pop happens in the same cycle
//   pop           : read request; ignored when empty
//   head          : entry at the read pointer, all zeros when empty
//   empty, full   : occupancy flags
//   count         : entries held, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds then.
    assign push_ok = push && (!full || pop_ok);

    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a FWFT FIFO.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   baud_tick  : one-clk enable at OVERSAMPLE x baud rate
//   RxD        : serial line, idle high, asynchronous to clk
//   rd_en      : pop the FIFO head (ignored when RDA is low)
//   clr_err    : clear sticky overrun
//   rx_data    : head payload, 0 when empty
//   frame_err  : head entry had a low stop sample
//   parity_err : head entry failed parity
//   RDA        : FIFO not empty
//   fifo_count : entries held
//   overrun    : sticky, a frame was dropped because the FIFO was full
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | line idle, looking for a low sample on a tick
// ST_START     | half-bit wait, then confirm the start bit is still low
// ST_DATA      | sample DATA_BITS payload bits, LSB first, one per bit time
// ST_PARITY    | sample the parity bit
// ST_STOP      | sample STOP_BITS stop bits; push entry on the last one
// ST_WAIT_IDLE | last stop sample was low (break); wait for line high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_tick,
    input  logic                          RxD,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          RDA,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam bit   HAS_PARITY = (PARITY_EN != 0);
    localparam bit   TWO_STOP   = (STOP_BITS == 2);
    localparam logic ODD_MODE   = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        rx_flags_t            flags;
    } rx_entry_t;

    logic                 rxd_meta;
    logic                 rxd_sync;
    rx_state_t            state;
    logic [CNT_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 sample_now;
    logic                 last_stop;
    logic                 push;
    logic                 pop;
    rx_entry_t            push_entry;
    rx_entry_t            head_entry;
    logic                 fifo_empty;
    logic                 fifo_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            rxd_sync <= rxd_meta;
        end
    end

    // Mid-bit sample point for data, parity and stop bits.
    assign sample_now = baud_tick && (tick_cnt == CNT_LAST);
    assign last_stop  = !TWO_STOP || stop_idx;
    assign push       = (state == ST_STOP) && sample_now && last_stop;
    assign pop        = rd_en && RDA;

    always_comb begin
        push_entry                  = '0;
        push_entry.data             = shift_reg;
        // Fold the final stop sample in directly; the register only holds
        // earlier stop samples.
        push_entry.flags.frame_err  = frame_err_r | ~rxd_sync;
        push_entry.flags.parity_err = parity_err_r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shift_reg    <= '0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (baud_tick && !rxd_sync) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (!rxd_sync) begin
                                state        <= ST_DATA;
                                bit_idx      <= '0;
                                stop_idx     <= 1'b0;
                                frame_err_r  <= 1'b0;
                                parity_err_r <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (sample_now) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rxd_sync, shift_reg[DATA_BITS-1:1]};
                            if (bit_idx == BIT_LAST) begin
                                state <= HAS_PARITY ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + BIT_W'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        if (sample_now) begin
                            tick_cnt     <= '0;
                            parity_err_r <= parity_mismatch(^shift_reg, rxd_sync, ODD_MODE);
                            state        <= ST_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (sample_now) begin
                            tick_cnt <= '0;
                            if (!rxd_sync) frame_err_r <= 1'b1;
                            if (last_stop) begin
                                state <= rxd_sync ? ST_IDLE : ST_WAIT_IDLE;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxd_sync) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A new overrun has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun <= 1'b1;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign RDA        = !fifo_empty;
    assign rx_data    = head_entry.data;
    assign frame_err  = head_entry.flags.frame_err;
    assign parity_err = head_entry.flags.parity_err;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver, successor to the fixed 8-bit single-buffer `receiver`. Oversamples `RxD` on a shared baud-tick enable, validates start, optional parity and 1 or 2 stop bits, then pushes each frame with its error flags into a small first-word-fall-through FIFO. Sits between the pad-side `RxD` line and the bus interface, which drains it via `rd_en`.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, legal range 5–9.
- `OVERSAMPLE`, default 16: `baud_tick` pulses per bit period; even, ≥ 4.
- `PARITY_EN`, default 0: 1 = a parity bit follows the data.
- `PARITY_ODD`, default 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: power of two, ≥ 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `baud_tick`  in  1  one-`clk` enable at `OVERSAMPLE` × baud rate.
- `RxD`  in  1  serial line, idle high, asynchronous to `clk`.
- `rd_en`  in  1  pops the FIFO head; ignored when `RDA`=0.
- `clr_err`  in  1  clears sticky `overrun`.
- `rx_data`  out  DATA_BITS  FIFO head payload; 0 when empty.
- `frame_err`  out  1  head entry had a bad stop bit.
- `parity_err`  out  1  head entry failed parity.
- `RDA`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `overrun`  out  1  sticky: a frame was dropped because the FIFO was full.

## Operation
- `RxD` passes through a 2-flop synchroniser, reset to 1; all sampling uses the synchronised value.
- Tick counter advances only on `baud_tick`; FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: synchronised `RxD` low on a tick → START, counter cleared.
- START: after `OVERSAMPLE/2` ticks, re-sample; low → DATA (counter cleared, bit index 0); high → IDLE (false start, nothing pushed).
- DATA: sample every `OVERSAMPLE` ticks, LSB first into shift register; after bit `DATA_BITS-1` → PARITY if `PARITY_EN` else STOP.
- PARITY: one sample; `parity_err` = XOR(data, sampled bit) ≠ `PARITY_ODD`.
- STOP: sample each of `STOP_BITS` bits; any low sample sets `frame_err`. After the last stop sample the entry {data, frame_err, parity_err} is pushed; → IDLE if last sample high, else WAIT_IDLE.
- WAIT_IDLE (break/framing recovery): stay until synchronised `RxD` high, then IDLE. No new start detected meanwhile.
- FIFO: first-word fall-through; `rx_data`/`frame_err`/`parity_err` show the head combinationally from storage. Pop when `rd_en && RDA`.
- Push when full without a same-cycle pop: frame dropped, `overrun` set; held until `clr_err` (clr_err and a new overrun in the same cycle: overrun wins).
- Push and pop in the same cycle: both succeed at any occupancy, `fifo_count` unchanged; no overrun when full.
- Pointers wrap modulo `FIFO_DEPTH`; `fifo_count` ranges 0..FIFO_DEPTH.

## Timing
- Reset values: FSM IDLE, counters 0, FIFO empty, `RDA`=0, `rx_data`=0, `frame_err`=0, `parity_err`=0, `fifo_count`=0, `overrun`=0.
- `RxD` to FSM: 2 `clk` synchroniser latency.
- Push occurs on the `clk` edge of the final stop-bit sample tick; `RDA` and `fifo_count` update on that same edge (visible next cycle).
- Pop: head advances on the `rd_en` edge; next entry visible the following cycle.
- Reset asserted mid-frame: partial frame discarded, FIFO contents lost, all outputs to reset values immediately.
- Stop sampling begins one full bit after the last data/parity sample; receiver is re-armed for a new start edge within the first half of the stop bit's end.

## Structure
- `uart_pkg`: `rx_state_t` enum, parity-mode constants, entry struct {data, frame_err, parity_err} (width set by `DATA_BITS` at instantiation via local typedef).
- One sub-module: `sync_fifo` (parametrised width/depth, FWFT, count output, simultaneous push/pop). Synchroniser and FSM stay in `uart_rx_fifo`.

## Test plan
- Defaults, 22 random bytes, tick every 5 `clk`, reader pops each → every `rx_data` matches sent byte, no errors, `fifo_count` returns to 0.
- `PARITY_EN`=1, `PARITY_ODD`=1: send 0x5A with parity 1 then with parity 0 → first entry `parity_err`=0, second `parity_err`=1.
- Stop bit held low for 0x00 (break), line low for 3 more bit times → one entry 0x00 with `frame_err`=1; no further entries until `RxD` returns high.
- 0.3-bit low glitch on idle `RxD` → no push, FSM back to IDLE, `RDA` stays 0.
- No reads, send 5 frames with `FIFO_DEPTH`=4 → `fifo_count`=4, `overrun`=1, first four bytes intact; `clr_err` → `overrun`=0; pop on push cycle when full → no overrun.
- `DATA_BITS`=7, `STOP_BITS`=2, reset deasserted mid-frame then frame 0x3C → reset clears state; 0x3C received cleanly.
